div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit signed/unsigned radix-2 restoring divider for the EX stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU operation from EX and asserts a stall request until the quotient and remainder are ready. The hazard unit ORs that request into stallF/stallD/stallE, so the instruction is held in EX until completion. The block honours the pipeline flush through an annul input.

## Interface

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start_i  in  1  EX holds a valid DIV/DIVU; held high by the stalled pipeline until ready_o.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept.
- dividend_i  in  WIDTH  rs value; sampled at accept.
- divisor_i  in  WIDTH  rt value; sampled at accept.
- annul_i  in  1  flush of EX; aborts any operation.
- stall_req_o  out  1  combinational; to hazard unit.
- ready_o  out  1  registered one-cycle result strobe.
- quotient_o  out  WIDTH  registered; written to LO.
- remainder_o  out  WIDTH  registered; written to HI.

## Operation

- FSM states are IDLE, BUSY and DONE.
- IDLE behaviour:
  - On start_i & !annul_i the block accepts the operation.
  - It latches |dividend| and |divisor| (absolute values only when signed_i), neg_q = signed_i & (dividend[31]^divisor[31]) and neg_r = signed_i & dividend[31].
  - It clears the 33-bit partial remainder and the 6-bit iteration counter.
  - If divisor_i == 0, it goes directly to DONE with quotient = 32'hFFFF_FFFF and remainder = dividend_i (raw, unsigned-unmodified). Otherwise it goes to BUSY.
- BUSY behaviour:
  - One iteration per cycle: trial = {rem[31:0], dvd[31]} − {1'b0, dsr}.
  - If trial[32]==0, rem ← trial and the quotient bit is 1. Otherwise rem ← {rem[31:0], dvd[31]} and the quotient bit is 0.
  - The dividend register shifts left and takes the quotient bit into bit 0.
  - After the iteration with counter == WIDTH−1, the state goes to DONE.
- DONE behaviour:
  - quotient_o ← neg_q ? −q : q and remainder_o ← neg_r ? −rem : rem, both mod 2^32.
  - ready_o = 1 for this cycle. The state goes to IDLE unconditionally.
- stall_req_o = !annul_i & ((IDLE & start_i) | BUSY). It is 0 in DONE, so the held instruction advances on the cycle the result is presented.
- quotient_o and remainder_o hold their values until the next DONE. Only DONE writes them.
- annul_i in any state:
  - The next state is IDLE and ready_o is 0 next cycle.
  - quotient_o and remainder_o are unchanged.
  - stall_req_o is 0 in the same cycle.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0, with no exception.
- start_i while BUSY or DONE is ignored, because it is the same held instruction.

## Timing

- Reset: with resetn low at a clock edge, the state becomes IDLE, the counter 0, and ready_o, quotient_o, remainder_o all 0. stall_req_o is forced 0 while resetn is low.
- Reset mid-operation aborts the operation with no ready_o pulse.
- Normal latency, with the accept edge as cycle 0:
  - BUSY in cycles 1..32, DONE in cycle 33.
  - stall_req_o is high in cycles 0..32, i.e. 33 stall cycles.
  - ready_o is high in cycle 33 only.
- Divide-by-zero latency: DONE in cycle 1, stall_req_o high in cycle 0 only, ready_o high in cycle 1.
- Back-to-back: a new start_i in the cycle after DONE, with the state back in IDLE, is accepted that cycle.
- annul_i together with the first start_i: nothing is accepted, the state stays IDLE, and stall_req_o = 0.

## Test plan

- Unsigned 100/7 (signed_i=0, start_i held):
  - stall_req_o high for 33 cycles.
  - ready_o in cycle 33 with quotient_o=14, remainder_o=2.
  - stall_req_o low in cycle 33.
- Signed −7/2 (0xFFFF_FFF9, 0x2) -> quotient_o=0xFFFF_FFFD, remainder_o=0xFFFF_FFFF.
- Signed 7/−2 -> quotient_o=0xFFFF_FFFD, remainder_o=1.
- Unsigned 0xFFFF_FFF9/2 -> quotient_o=0x7FFF_FFFC, remainder_o=1.
- Signed 0x8000_0000/0xFFFF_FFFF -> quotient_o=0x8000_0000, remainder_o=0 after 33 cycles.
- Divisor 0 with dividend 0x1234 -> ready_o in cycle 1 with quotient_o=0xFFFF_FFFF, remainder_o=0x1234, and exactly one stall cycle.
- Annul: start 100/7, assert annul_i in cycle 10:
  - stall_req_o 0 that cycle, and no ready_o pulse follows.
  - quotient_o and remainder_o keep their previous values.
  - A new start of 9/3 on the next cycle gives quotient_o=3, remainder_o=0 at cycle 33 after its accept.
- Reset mid-operation: drop resetn in cycle 15 of a division -> next cycle all outputs are 0 with the state IDLE. After release, a 50/5 division completes normally with quotient_o=10, remainder_o=0.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Latency: accept edge = cycle 0, BUSY cycles 1..WIDTH, result + ready_o in cycle WIDTH+1 (cycle 1 for divide-by-zero).
// Backpressure: none downstream; stall_req_o holds the pipeline until the result strobe, annul_i aborts at once.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   start_i, signed_i           operation request (held while stalled), 1 = signed DIV
//   dividend_i, divisor_i       rs / rt operands, sampled at accept
//   annul_i                     EX flush, aborts any operation
//   stall_req_o                 combinational stall request to the hazard unit
//   ready_o                     one-cycle result strobe
//   quotient_o, remainder_o     registered results (LO / HI), held until the next result
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;   // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dsr;   // |divisor|
  // Working remainder is WIDTH+1 bits during the trial subtraction, but the
  // stored value is always below the divisor, so its top bit is never kept.
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last;

  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};
  assign qbit    = ~trial[WIDTH];
  assign rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_nxt   = {dvd[WIDTH-2:0], qbit};
  assign last    = (cnt == CW'(WIDTH - 1));

  assign abs_a = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign abs_b = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // Low in DONE so the held instruction advances the cycle the result appears.
  assign stall_req_o = resetn && !annul_i &&
                       (((state == IDLE) && start_i) || (state == BUSY));

  // Results and ready_o are loaded on the edge that enters DONE, so they are
  // visible throughout the DONE cycle together with the strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else if (annul_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= abs_a;
            dsr   <= abs_b;
            neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r <= signed_i & dividend_i[WIDTH-1];
            if (divisor_i == '0) begin
              // Divide-by-zero: all-ones quotient, raw dividend as remainder.
              state       <= DONE;
              ready_o     <= 1'b1;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state       <= DONE;
            ready_o     <= 1'b1;
            quotient_o  <= neg_q ? -q_nxt : q_nxt;
            remainder_o <= neg_r ? -rem_nxt : rem_nxt;
          end
        end
        DONE: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
